// File: rtl/clock_time_core.sv
// 24-hour BCD time-keeping core: 1 Hz prescaler, HH:MM:SS counters with
// adjust pulses, and a fixed-time alarm that drives an 18-bit LED pattern.
module clock_time_core #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned ALARM_HOUR = 7,
  parameter int unsigned ALARM_MIN  = 0,
  parameter int unsigned ALARM_LEN  = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_en,
  input  logic        adj_min,
  input  logic        adj_hour,
  output logic [3:0]  min_units,
  output logic [3:0]  min_tens,
  output logic [3:0]  hour_units,
  output logic [3:0]  hour_tens,
  output logic        sec_tick,
  output logic        alarm_active,
  output logic [17:0] alarm_signal
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [23:0] ALARM_BCD = {4'(ALARM_HOUR / 10), 4'(ALARM_HOUR % 10),
                                       4'(ALARM_MIN / 10), 4'(ALARM_MIN % 10), 8'h00};
  localparam logic [7:0] ALARM_CNT = 8'(ALARM_LEN);

  typedef enum logic [0:0] {IDLE = 1'b0, RING = 1'b1} state_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sec_u_q, sec_u_d, sec_t_q, sec_t_d;
  logic [3:0]    min_u_q, min_u_d, min_t_q, min_t_d;
  logic [3:0]    hr_u_q, hr_u_d, hr_t_q, hr_t_d;
  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          sec_tick_q;
  logic [17:0]   alarm_sig_q, alarm_sig_d;

  logic tick_c, adv_c, sec_wrap_c, min_wrap_c, min_inc_c, hr_inc_c, match_c;
  logic [23:0] time_q_c, time_d_c;

  // Prescaler: free-runs while enabled, cleared when stopped or on minute adjust
  always_comb begin
    presc_d = presc_q + PW'(1);
    tick_c  = 1'b0;
    if (!run_en) begin
      presc_d = '0;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      tick_c  = 1'b1;
    end
    if (adj_min) presc_d = '0;
  end

  // A minute adjust swallows a coincident tick
  assign adv_c      = tick_c & ~adj_min;
  assign sec_wrap_c = (sec_t_q == 4'd5) && (sec_u_q == 4'd9);
  assign min_wrap_c = (min_t_q == 4'd5) && (min_u_q == 4'd9);
  assign min_inc_c  = adj_min | (adv_c & sec_wrap_c);
  // Adjust and tick carry share one increment so the hour never jumps by two
  assign hr_inc_c   = adj_hour | (adv_c & sec_wrap_c & min_wrap_c);

  // Next-time BCD counters
  always_comb begin
    sec_u_d = sec_u_q;
    sec_t_d = sec_t_q;
    min_u_d = min_u_q;
    min_t_d = min_t_q;
    hr_u_d  = hr_u_q;
    hr_t_d  = hr_t_q;
    if (adj_min) begin
      sec_u_d = 4'd0;
      sec_t_d = 4'd0;
    end else if (adv_c) begin
      if (sec_u_q == 4'd9) begin
        sec_u_d = 4'd0;
        sec_t_d = sec_wrap_c ? 4'd0 : sec_t_q + 4'd1;
      end else begin
        sec_u_d = sec_u_q + 4'd1;
      end
    end
    if (min_inc_c) begin
      if (min_u_q == 4'd9) begin
        min_u_d = 4'd0;
        min_t_d = min_wrap_c ? 4'd0 : min_t_q + 4'd1;
      end else begin
        min_u_d = min_u_q + 4'd1;
      end
    end
    if (hr_inc_c) begin
      if ((hr_t_q == 4'd2) && (hr_u_q == 4'd3)) begin
        hr_u_d = 4'd0;
        hr_t_d = 4'd0;
      end else if (hr_u_q == 4'd9) begin
        hr_u_d = 4'd0;
        hr_t_d = hr_t_q + 4'd1;
      end else begin
        hr_u_d = hr_u_q + 4'd1;
      end
    end
  end

  assign time_q_c = {hr_t_q, hr_u_q, min_t_q, min_u_q, sec_t_q, sec_u_q};
  assign time_d_c = {hr_t_d, hr_u_d, min_t_d, min_u_d, sec_t_d, sec_u_d};
  // Only the transition onto the alarm time triggers, not dwelling on it
  assign match_c  = (time_d_c == ALARM_BCD) && (time_q_c != ALARM_BCD);

  // Alarm FSM next state, countdown and LED pattern
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alarm_sig_d = 18'h00000;
    case (state_q)
      IDLE: begin
        if (match_c) begin
          state_d = RING;
          cnt_d   = ALARM_CNT;
        end
      end
      RING: begin
        if (adj_min || adj_hour) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (adv_c) begin
          if (cnt_q <= 8'd1) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    if ((state_d == RING) && !sec_u_d[0]) alarm_sig_d = 18'h3FFFF;
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q     <= '0;
      sec_u_q     <= 4'd0;
      sec_t_q     <= 4'd0;
      min_u_q     <= 4'd0;
      min_t_q     <= 4'd0;
      hr_u_q      <= 4'd0;
      hr_t_q      <= 4'd0;
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      sec_tick_q  <= 1'b0;
      alarm_sig_q <= 18'h00000;
    end else begin
      presc_q     <= presc_d;
      sec_u_q     <= sec_u_d;
      sec_t_q     <= sec_t_d;
      min_u_q     <= min_u_d;
      min_t_q     <= min_t_d;
      hr_u_q      <= hr_u_d;
      hr_t_q      <= hr_t_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sec_tick_q  <= adv_c;
      alarm_sig_q <= alarm_sig_d;
    end
  end

  assign min_units    = min_u_q;
  assign min_tens     = min_t_q;
  assign hour_units   = hr_u_q;
  assign hour_tens    = hr_t_q;
  assign sec_tick     = sec_tick_q;
  assign alarm_active = (state_q == RING);
  assign alarm_signal = alarm_sig_q;

endmodule

// File: tb/tb_clock_time_core.sv
// Bench for clock_time_core: seconds-of-day reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_clock_time_core;

  localparam int TICK_DIV   = 4;
  localparam int ALARM_HOUR = 7;
  localparam int ALARM_MIN  = 0;
  localparam int ALARM_LEN  = 3;
  localparam int ALARM_T    = ALARM_HOUR * 3600 + ALARM_MIN * 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_en = 1'b0;
  logic        adj_min = 1'b0;
  logic        adj_hour = 1'b0;
  logic [3:0]  min_units, min_tens, hour_units, hour_tens;
  logic        sec_tick, alarm_active;
  logic [17:0] alarm_signal;

  clock_time_core #(
    .TICK_DIV(TICK_DIV), .ALARM_HOUR(ALARM_HOUR),
    .ALARM_MIN(ALARM_MIN), .ALARM_LEN(ALARM_LEN)
  ) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .adj_min(adj_min), .adj_hour(adj_hour),
    .min_units(min_units), .min_tens(min_tens), .hour_units(hour_units),
    .hour_tens(hour_tens), .sec_tick(sec_tick), .alarm_active(alarm_active),
    .alarm_signal(alarm_signal)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit spacing_en = 1'b0;
  int n_ticks = 0;
  int cyc = 0;
  int last_tick = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] hhmm(input int t);
    int h, m;
    h = t / 3600;
    m = (t / 60) % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  // Reference model: time as seconds since midnight, alarm as seconds left
  int m_t = 0, m_presc = 0, m_ring = 0;
  bit m_tick = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_t = 0; m_presc = 0; m_ring = 0; m_tick = 1'b0;
    end else begin
      int h, m, s, nt;
      bit tk, carry;
      tk = run_en && (m_presc == TICK_DIV - 1);
      if (!run_en || adj_min || tk) m_presc = 0;
      else m_presc = m_presc + 1;
      h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
      carry = 1'b0;
      if (adj_min) begin
        m = (m + 1) % 60; s = 0;
      end else if (tk) begin
        nt = (m_t + 1) % 86400;
        carry = (s == 59) && (m == 59);
        h = nt / 3600; m = (nt / 60) % 60; s = nt % 60;
      end
      if (adj_hour && !carry) h = (h + 1) % 24;
      nt = h * 3600 + m * 60 + s;
      m_tick = tk && !adj_min;
      if (m_ring == 0) begin
        if (nt == ALARM_T && nt != m_t) m_ring = ALARM_LEN;
      end else if (adj_min || adj_hour) begin
        m_ring = 0;
      end else if (m_tick) begin
        m_ring = m_ring - 1;
      end
      m_t = nt;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare against the model, plus tick counting and spacing
  always @(negedge clk) begin
    if (chk_en) begin
      chk("time", {hour_tens, hour_units, min_tens, min_units}, hhmm(m_t));
      chk("sec_tick", sec_tick, m_tick);
      chk("alarm_active", alarm_active, m_ring != 0);
      chk("alarm_signal", alarm_signal,
          (m_ring != 0 && ((m_t % 10) % 2 == 0)) ? 18'h3FFFF : 18'h0);
      if (sec_tick) begin
        n_ticks++;
        if (spacing_en && last_tick >= 0) chk("tick_gap", cyc - last_tick, 4);
        last_tick = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_min();
    adj_min = 1'b1; step(); adj_min = 1'b0; step();
  endtask

  task automatic pulse_hour();
    adj_hour = 1'b1; step(); adj_hour = 1'b0; step();
  endtask

  task automatic run_ticks(input int n);
    run_en = 1'b1;
    repeat (4 * n) step();
    run_en = 1'b0;
    step();
  endtask

  function automatic logic [15:0] dig();
    return {hour_tens, hour_units, min_tens, min_units};
  endfunction

  initial begin
    #1 rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_time", dig(), 16'h0000);
    chk("rst_tick", sec_tick, 1'b0);
    chk("rst_alarm", alarm_active, 1'b0);
    chk("rst_sig", alarm_signal, 18'h0);
    step(); step();
    rst = 1'b1;

    // 240 cycles at TICK_DIV=4 give 60 ticks
    spacing_en = 1'b1;
    run_en = 1'b1;
    repeat (240) step();
    run_en = 1'b0;
    step();
    spacing_en = 1'b0;
    chk("t1_ticks", n_ticks, 60);
    chk("t1_time", dig(), 16'h0001);

    // Adjust rollovers
    repeat (9) pulse_hour();
    repeat (58) pulse_min();
    chk("t3_0959", dig(), 16'h0959);
    pulse_min();
    chk("t3_0900", dig(), 16'h0900);
    pulse_hour();
    chk("t3_1000", dig(), 16'h1000);
    repeat (13) pulse_hour();
    chk("t3_2300", dig(), 16'h2300);
    pulse_hour();
    chk("t3_0000", dig(), 16'h0000);

    // Full-day wrap
    repeat (23) pulse_hour();
    repeat (59) pulse_min();
    run_ticks(58);
    chk("t2_2359_58", dig(), 16'h2359);
    run_ticks(1);
    chk("t2_2359_59", dig(), 16'h2359);
    run_ticks(1);
    chk("t2_wrap", dig(), 16'h0000);

    // adj_hour coinciding with tick-driven hour carry, landing on the alarm
    repeat (6) pulse_hour();
    repeat (59) pulse_min();
    run_ticks(59);
    chk("t4_0659", dig(), 16'h0659);
    run_en = 1'b1;
    repeat (3) step();
    adj_hour = 1'b1;
    step();
    adj_hour = 1'b0;
    chk("t4_0700", dig(), 16'h0700);
    chk("t4_ring", alarm_active, 1'b1);
    chk("t4_sig0", alarm_signal, 18'h3FFFF);
    chk("t4_tick", sec_tick, 1'b1);
    repeat (4) step();
    chk("t4_act1", alarm_active, 1'b1);
    chk("t4_sig1", alarm_signal, 18'h00000);
    repeat (4) step();
    chk("t4_sig2", alarm_signal, 18'h3FFFF);
    repeat (4) step();
    chk("t4_end", alarm_active, 1'b0);
    chk("t4_sig3", alarm_signal, 18'h00000);

    // adj_min coinciding with a tick: tick dropped
    repeat (3) step();
    adj_min = 1'b1;
    step();
    adj_min = 1'b0;
    chk("col_time", dig(), 16'h0701);
    chk("col_tick", sec_tick, 1'b0);
    run_en = 1'b0;
    step();

    // Alarm reached by adjust, cancelled by adj_hour
    repeat (59) pulse_min();
    chk("t5_ring", alarm_active, 1'b1);
    adj_hour = 1'b1;
    step();
    adj_hour = 1'b0;
    chk("t5_cancel", alarm_active, 1'b0);
    chk("t5_sig", alarm_signal, 18'h0);
    chk("t5_time", dig(), 16'h0800);

    // Frozen while stopped, then async reset mid-ring
    repeat (23) pulse_hour();
    chk("t6_ring", alarm_active, 1'b1);
    begin
      int n0;
      n0 = n_ticks;
      repeat (100) step();
      chk("t6_noticks", n_ticks, n0);
      chk("t6_frozen", dig(), 16'h0700);
    end
    rst = 1'b0;
    #1;
    chk("t6_rst_time", dig(), 16'h0000);
    chk("t6_rst_act", alarm_active, 1'b0);
    chk("t6_rst_sig", alarm_signal, 18'h0);
    chk("t6_rst_tick", sec_tick, 1'b0);
    step();
    rst = 1'b1;
    step();
    chk("t6_after", dig(), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/clock_time_core.md
Name: clock_time_core

Overview:
Time-keeping core that sits directly upstream of the clock's display and LED stage. It divides the board clock into a 1 Hz tick and keeps a 24-hour HH:MM:SS count in BCD. It takes debounced adjust pulses, compares the time against a fixed alarm time, and produces the four BCD digits (minute units/tens, hour units/tens) that feed the seven-segment decoders. It also drives the 18-bit alarm LED vector.

Parameters:
TICK_DIV, 50000000, board-clock cycles per 1-second tick (≥2; benches use 4)
ALARM_HOUR, 7, alarm hour, 0..23 binary
ALARM_MIN, 0, alarm minute, 0..59 binary
ALARM_LEN, 60, alarm duration in seconds, 1..255

Ports:
clk  input  1  board clock
rst  input  1  asynchronous, active-low reset
run_en  input  1  1 = time advances on ticks; 0 = time frozen, prescaler held at 0
adj_min  input  1  single-cycle pulse, synchronous, pre-debounced: minute +1
adj_hour  input  1  single-cycle pulse, synchronous, pre-debounced: hour +1
min_units  output  4  BCD 0..9
min_tens  output  4  BCD 0..5
hour_units  output  4  BCD 0..9 (0..3 when hour_tens=2)
hour_tens  output  4  BCD 0..2
sec_tick  output  1  one-cycle pulse when the seconds counter advances
alarm_active  output  1  high while the alarm is sounding
alarm_signal  output  18  LED pattern

Behaviour:
- Reset (rst=0, async): all digits 0 (00:00), seconds 0, prescaler 0, sec_tick=0, alarm_active=0, alarm_signal=0, alarm countdown 0. All outputs are registered.
- Prescaler: counts 0..TICK_DIV-1 while run_en=1. At TICK_DIV-1 it wraps to 0 and asserts sec_tick for that one cycle. When run_en=0 the prescaler clears to 0 and no ticks occur.
- Seconds: held as BCD tens/units (00..59), incremented on sec_tick. 59→00 carries +1 to the minute.
- Minute increment: units 9→0 with tens+1; 59→00 carries +1 to the hour when the source is a seconds carry.
- Hour increment: 23→00, and 09→10 / 19→20 BCD rollovers. Full wrap: 23:59:59 → 00:00:00 on one tick.
- adj_min: minute +1 with wrap 59→00 and no hour carry. Seconds are also cleared to 00 and the prescaler to 0.
- adj_hour: hour +1 with wrap 23→00. Minutes and seconds are unchanged.
- Simultaneous events, same cycle:
  - adj_min + sec_tick: the adjust wins, the tick is dropped, and seconds become 00.
  - adj_hour + tick-driven hour carry: the hour advances by exactly +1 (no double increment); minutes and seconds apply the tick normally.
  - adj_min + adj_hour: both apply.
- Alarm FSM, states IDLE / RING:
  - IDLE→RING on the cycle the registered time becomes ALARM_HOUR:ALARM_MIN:00, whether reached by tick or by adjust. The countdown loads ALARM_LEN.
  - RING: the countdown decrements on each sec_tick. RING→IDLE when the countdown reaches 0, or on any adj_min/adj_hour pulse, which acts as snooze-cancel.
  - A second match while in RING does not restart the countdown.
  - alarm_active=1 exactly in RING.
- alarm_signal: 0 in IDLE. In RING it is 18'h3FFFF when seconds units is even and 18'h00000 when odd, updated in the same cycle as the digits.
- Reset asserted mid-RING returns the block immediately to IDLE with all outputs 0.
- No combinational path from inputs to outputs.

Test Plan:
1. TICK_DIV=4. Release reset, hold run_en=1 for 4×60 cycles → exactly 60 sec_tick pulses spaced 4 cycles apart; digits read 00:01.
2. Preload to 23:59:58 via adj pulses and ticks, then apply 2 ticks → 23:59:59, then 00:00:00, all four digits 0.
3. At 09:59, pulse adj_min → 09:00 with hour unchanged. Pulse adj_hour at 09 → 10 (hour_tens=1, hour_units=0). Pulse adj_hour at 23 → 00.
4. ALARM 07:00, ALARM_LEN=3: reach 07:00:00 → alarm_active=1, alarm_signal=3FFFF. Next tick → 0. Next → 3FFFF. The alarm clears after the 3rd tick.
5. In RING, pulse adj_hour → alarm_active=0 and alarm_signal=0 on the next cycle; hour +1.
6. run_en=0 for 100 cycles → no sec_tick and digits frozen. Then assert rst mid-RING → all outputs 0 immediately, asynchronously, before the next clk edge.
